// File: rtl/strip_pad_data_encoder.sv
// strip_pad_data_encoder
// Transmit-side framer for the sTGC TDS link. Takes strip (104-bit) or pad
// (116-bit) hit packets over valid/ready and emits 16-bit GTP TX words:
// idle K28.5 words, a K28.1 start-of-frame carrying a sequence number, the
// byte-sliced packet, and an XOR checksum byte, followed by a short idle gap.
module strip_pad_data_encoder #(
  parameter int SYNC_WORDS = 256,
  parameter int MIN_GAP    = 2
) (
  input  logic         clk160,
  input  logic         reset,
  input  logic         enable,
  input  logic         tds_mode,
  input  logic [115:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic [15:0]  tx_data,
  output logic [1:0]   tx_charisk,
  output logic         linked,
  output logic [15:0]  frame_cnt
);

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    SOF,
    PAYLOAD,
    GAP
  } state_t;

  localparam logic [15:0] IDLE_WORD = 16'h50BC;
  localparam logic [7:0]  SOF_K     = 8'h3C;
  localparam logic [15:0] SYNC_LAST = 16'(SYNC_WORDS - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(MIN_GAP - 1);

  logic         rst_n;
  state_t       state, state_n;
  logic [2:0]   word_idx, idx_n;
  logic [3:0]   gap_cnt, gap_n;
  logic [15:0]  sync_cnt, sync_n;
  logic [7:0]   seq, seq_n;
  logic [15:0]  frame_n;
  logic         linked_n;
  logic         ready_n;
  logic [15:0]  tx_data_n;
  logic [1:0]   charisk_n;
  logic [15:0]  word_sel;
  logic [127:0] packet;
  logic         strip_mode;
  logic [7:0]   strip_csum;
  logic [7:0]   pad_csum;
  logic [2:0]   last_idx;
  logic         take;

  assign take     = data_valid && data_ready;
  assign last_idx = strip_mode ? 3'd6 : 3'd7;

  // Reset asserts immediately but releases on a clock edge, so the SYNC count starts cleanly
  always_ff @(posedge clk160 or negedge reset) begin
    if (!reset) rst_n <= 1'b0;
    else        rst_n <= 1'b1;
  end

  // Hold the accepted packet so later input changes cannot disturb the frame in flight
  always_ff @(posedge clk160 or negedge rst_n) begin
    if (!rst_n) begin
      packet     <= '0;
      strip_mode <= 1'b0;
    end else if (take) begin
      packet     <= tds_mode ? {24'b0, data_in[103:0]} : {12'b0, data_in};
      strip_mode <= tds_mode;
    end
  end

  // XOR checksums over the captured bytes: 13 bytes for strip, 15 for pad
  always_comb begin
    strip_csum = 8'h00;
    for (int b = 0; b < 13; b++) begin
      strip_csum = strip_csum ^ packet[b*8 +: 8];
    end
    pad_csum = strip_csum ^ packet[111:104] ^ packet[119:112];
  end

  // Next-state, counters and the word to be driven in the next cycle
  always_comb begin
    state_n   = state;
    idx_n     = word_idx;
    gap_n     = gap_cnt;
    sync_n    = sync_cnt;
    seq_n     = seq;
    frame_n   = frame_cnt;
    linked_n  = linked;
    tx_data_n = IDLE_WORD;
    charisk_n = 2'b01;
    word_sel  = 16'h0000;

    case (state)
      SYNC: begin
        if (sync_cnt == SYNC_LAST) begin
          state_n  = IDLE;
          linked_n = 1'b1;
        end else begin
          sync_n = sync_cnt + 16'd1;
        end
      end
      IDLE: begin
        if (take) state_n = SOF;
      end
      SOF: begin
        state_n = PAYLOAD;
        idx_n   = 3'd0;
      end
      PAYLOAD: begin
        if (word_idx == last_idx) begin
          state_n = GAP;
          gap_n   = 4'd0;
          seq_n   = seq + 8'd1;
          frame_n = frame_cnt + 16'd1;
        end else begin
          idx_n = word_idx + 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = take ? SOF : IDLE;
        else                     gap_n   = gap_cnt + 4'd1;
      end
      default: state_n = SYNC;
    endcase

    ready_n = enable && ((state_n == IDLE) || ((state_n == GAP) && (gap_n == GAP_LAST)));

    word_sel = packet[{idx_n, 4'b0000} +: 16];
    if (strip_mode && (idx_n == 3'd6))       word_sel = {strip_csum, packet[103:96]};
    else if (!strip_mode && (idx_n == 3'd7)) word_sel = {pad_csum, packet[119:112]};

    if (state_n == SOF) begin
      tx_data_n = {seq_n, SOF_K};
      charisk_n = 2'b01;
    end else if (state_n == PAYLOAD) begin
      tx_data_n = word_sel;
      charisk_n = 2'b00;
    end
  end

  // State register and registered GTP outputs
  always_ff @(posedge clk160 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      word_idx   <= 3'd0;
      gap_cnt    <= 4'd0;
      sync_cnt   <= 16'd0;
      seq        <= 8'd0;
      frame_cnt  <= 16'd0;
      linked     <= 1'b0;
      data_ready <= 1'b0;
      tx_data    <= IDLE_WORD;
      tx_charisk <= 2'b01;
    end else begin
      state      <= state_n;
      word_idx   <= idx_n;
      gap_cnt    <= gap_n;
      sync_cnt   <= sync_n;
      seq        <= seq_n;
      frame_cnt  <= frame_n;
      linked     <= linked_n;
      data_ready <= ready_n;
      tx_data    <= tx_data_n;
      tx_charisk <= charisk_n;
    end
  end

endmodule

// File: tb/tb_strip_pad_data_encoder.sv
// Testbench for strip_pad_data_encoder: directed packets, expected words
// queued at issue time, monitor compares every non-idle word on tx_data.
module tb_strip_pad_data_encoder;

  localparam int SYNC_WORDS = 4;
  localparam int MIN_GAP    = 2;
  localparam logic [15:0] IDLE_WORD = 16'h50BC;

  logic         clk160     = 1'b0;
  logic         reset      = 1'b1;
  logic         enable     = 1'b0;
  logic         tds_mode   = 1'b0;
  logic [115:0] data_in    = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic [15:0]  tx_data;
  logic [1:0]   tx_charisk;
  logic         linked;
  logic [15:0]  frame_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  tb_seq    = 8'h00;
  int          tb_frames = 0;
  bit          mon_on     = 1'b0;
  bit          period_chk = 1'b0;
  bit          have_sof   = 1'b0;
  int          cycle      = 0;
  int          last_sof   = 0;

  strip_pad_data_encoder #(
    .SYNC_WORDS(SYNC_WORDS),
    .MIN_GAP   (MIN_GAP)
  ) dut (
    .clk160    (clk160),
    .reset     (reset),
    .enable    (enable),
    .tds_mode  (tds_mode),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx_data   (tx_data),
    .tx_charisk(tx_charisk),
    .linked    (linked),
    .frame_cnt (frame_cnt)
  );

  // 160 MHz-style clock, 10 ns period in simulation
  always #5 clk160 = ~clk160;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push_word(input logic [1:0] k, input logic [15:0] w);
    exp_q.push_back({k, w});
  endtask

  // Reference model: byte-slice, XOR checksum, pair bytes into words
  task automatic push_frame(input bit strip, input logic [115:0] d);
    logic [119:0] ext;
    logic [7:0]   bytes[16];
    logic [7:0]   csum;
    int           nb;
    ext  = strip ? {16'b0, d[103:0]} : {4'b0, d};
    nb   = strip ? 13 : 15;
    csum = 8'h00;
    for (int b = 0; b < 16; b++) bytes[b] = 8'h00;
    for (int b = 0; b < nb; b++) begin
      bytes[b] = ext[b*8 +: 8];
      csum     = csum ^ bytes[b];
    end
    bytes[nb] = csum;
    push_word(2'b01, {tb_seq, 8'h3C});
    for (int w = 0; w < (nb + 1) / 2; w++) push_word(2'b00, {bytes[2*w+1], bytes[2*w]});
    tb_seq++;
    tb_frames++;
  endtask

  // Offer one packet and wait (bounded) for the handshake to complete
  task automatic applyStimulus(input bit strip, input logic [115:0] d);
    int n;
    data_in    = d;
    tds_mode   = strip;
    data_valid = 1'b1;
    n = 0;
    while (!data_ready && n < 400) begin
      @(negedge clk160);
      n++;
    end
    if (!data_ready) begin
      checkOutput("ready_timeout", {31'b0, data_ready}, 32'd1);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk160);
    #1;
    data_valid = 1'b0;
    data_in    = {$urandom, $urandom, $urandom, $urandom};
    tds_mode   = ~strip;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk160);
      n++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
    repeat (MIN_GAP + 1) @(negedge clk160);
  endtask

  task automatic assert_reset();
    reset  = 1'b0;
    mon_on = 1'b0;
    #1;
    checkOutput("rst_tx", {14'b0, tx_charisk, tx_data}, {14'b0, 2'b01, IDLE_WORD});
    checkOutput("rst_ready", {31'b0, data_ready}, 32'd0);
    checkOutput("rst_linked", {31'b0, linked}, 32'd0);
    checkOutput("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    exp_q.delete();
    tb_seq    = 8'h00;
    tb_frames = 0;
  endtask

  task automatic release_reset();
    @(negedge clk160);
    reset = 1'b1;
    for (int i = 1; i <= SYNC_WORDS + 1; i++) begin
      @(posedge clk160);
      #1;
      checkOutput("sync_word", {14'b0, tx_charisk, tx_data}, {14'b0, 2'b01, IDLE_WORD});
      checkOutput("sync_linked", {31'b0, linked}, (i == SYNC_WORDS + 1) ? 32'd1 : 32'd0);
      if (i <= SYNC_WORDS) checkOutput("sync_ready", {31'b0, data_ready}, 32'd0);
    end
    mon_on = 1'b1;
  endtask

  // Monitor: every non-idle word must match the head of the expected queue
  always @(negedge clk160) begin
    cycle++;
    if (mon_on && !(tx_data == IDLE_WORD && tx_charisk == 2'b01)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", {14'b0, tx_charisk, tx_data}, {14'b0, 2'b01, IDLE_WORD});
      end else begin
        checkOutput("tx_word", {14'b0, tx_charisk, tx_data}, {14'b0, exp_q.pop_front()});
      end
      if (tx_charisk == 2'b01 && tx_data[7:0] == 8'h3C) begin
        if (period_chk && have_sof) checkOutput("sof_period", cycle - last_sof, 1 + 7 + MIN_GAP);
        have_sof = 1'b1;
        last_sof = cycle;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] pat;
    enable = 1'b1;

    @(posedge clk160);
    #2;
    assert_reset();
    release_reset();

    // Strip packet with hand-computed words
    push_word(2'b01, 16'h003C);
    push_word(2'b00, 16'h0201);
    push_word(2'b00, 16'h0403);
    push_word(2'b00, 16'h0605);
    push_word(2'b00, 16'h0807);
    push_word(2'b00, 16'h0A09);
    push_word(2'b00, 16'h0C0B);
    push_word(2'b00, 16'h010D);
    tb_seq++;
    tb_frames++;
    applyStimulus(1'b1, 116'h0D0C0B0A090807060504030201);
    wait_drain();
    checkOutput("strip_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // Pad packet, all ones
    @(posedge clk160);
    #2;
    assert_reset();
    release_reset();
    push_word(2'b01, 16'h003C);
    for (int i = 0; i < 7; i++) push_word(2'b00, 16'hFFFF);
    push_word(2'b00, 16'h0F0F);
    tb_seq++;
    tb_frames++;
    applyStimulus(1'b0, {116{1'b1}});
    wait_drain();
    checkOutput("pad_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // 300 back-to-back strip frames
    @(posedge clk160);
    #2;
    assert_reset();
    release_reset();
    period_chk = 1'b1;
    have_sof   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pat = {4{32'(i) * 32'h9E3779B1}};
      push_frame(1'b1, pat[115:0]);
      applyStimulus(1'b1, pat[115:0]);
    end
    wait_drain();
    period_chk = 1'b0;
    checkOutput("b2b_frame_cnt", {16'b0, frame_cnt}, 32'd300);
    checkOutput("b2b_model_cnt", {16'b0, frame_cnt}, tb_frames);

    // Enable dropped during payload word 3
    push_frame(1'b1, 116'h0_1234_5678_9ABC_DEF0_1357_9BDF);
    applyStimulus(1'b1, 116'h0_1234_5678_9ABC_DEF0_1357_9BDF);
    repeat (5) @(posedge clk160);
    #1;
    enable = 1'b0;
    wait_drain();
    checkOutput("en_frame_cnt", {16'b0, frame_cnt}, 32'd301);
    data_valid = 1'b1;
    data_in    = 116'hA_BCDE_F012_3456_789A_BCDE_F012_3456;
    tds_mode   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk160);
      checkOutput("disabled_ready", {31'b0, data_ready}, 32'd0);
    end
    data_valid = 1'b0;
    enable     = 1'b1;
    repeat (2) @(negedge clk160);
    checkOutput("reenabled_ready", {31'b0, data_ready}, 32'd1);

    // Reset during payload word 4 of a pad frame
    push_frame(1'b0, 116'h5_A5A5_A5A5_5A5A_5A5A_1111_2222_3333);
    applyStimulus(1'b0, 116'h5_A5A5_A5A5_5A5A_5A5A_1111_2222_3333);
    repeat (6) @(posedge clk160);
    #2;
    assert_reset();
    release_reset();
    push_frame(1'b1, 116'h0_0000_00FE_DCBA_9876_5432_1000);
    applyStimulus(1'b1, 116'h0_0000_00FE_DCBA_9876_5432_1000);
    wait_drain();
    checkOutput("post_reset_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
